div_arbiter: RTL and testbench
==============================

DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameter TAMANYO, 4, operand/result width in bits.
REQ-002 Parameter LATENCIA, 16, fixed divider pipeline depth in cycles from div_start to result on div_coc/div_res.
REQ-003 CLK  input  1  single clock; all logic on rising edge.
REQ-004 RSTa  input  1  reset, synchronous, active-low.
REQ-005 EN  input  1  global enable; 0 blocks new grants, in-flight results still drain.
REQ-006 req0_valid, req1_valid  input  1 each  requester has an operation pending.
REQ-007 req0_num, req0_den, req1_num, req1_den  input  TAMANYO each  requester operands.
REQ-008 req0_ready, req1_ready  output  1 each  grant; transfer occurs when valid and ready are both 1.
REQ-009 div_start  output  1  registered issue strobe to the divider.
REQ-010 div_num, div_den  output  TAMANYO each  registered operands to the divider.
REQ-011 div_coc, div_res  input  TAMANYO each  divider quotient/remainder.
REQ-012 res0_valid, res1_valid  output  1 each  one-cycle result strobe per requester.
REQ-013 res0_coc, res0_res, res1_coc, res1_res  output  TAMANYO each  registered result per requester.
REQ-014 res0_err, res1_err  output  1 each  divide-by-zero flag, qualified by resN_valid.
REQ-015 OCUPADO  output  clog2(LATENCIA+2)  count of operations in flight.

Function
REQ-016 At most one grant per cycle; reqN_ready is combinational from reqN_valid, EN and the round-robin pointer.
REQ-017 Only one requester valid with EN=1: that requester is granted.
REQ-018 Both valid with EN=1: the requester not granted last is granted; pointer updates only on an actual transfer.
REQ-019 A transfer in cycle t drives div_start=1 with the granted operands in cycle t+1; otherwise div_start=0 and div_num/div_den hold their last values.
REQ-020 Each issue pushes a tag {valid, id, err} into a LATENCIA-deep shift register advancing every cycle, never stalling.
REQ-021 err=1 when the accepted den equals 0; the operation is still issued to preserve slot ordering.
REQ-022 When the tag exits (cycle t+1+LATENCIA), div_coc/div_res are captured into the id's result registers; resN_valid=1 in cycle t+2+LATENCIA; total latency LATENCIA+2.
REQ-023 err=1 results: resN_coc forced to all ones, resN_res forced to 0, resN_err=1.
REQ-024 Result registers of the non-addressed requester hold their value; resN_valid is 0 in every cycle without a matching exit.
REQ-025 Back-to-back transfers are allowed every cycle, giving one result per cycle.
REQ-026 OCUPADO increments on issue, decrements on result strobe, and is unchanged when both occur in the same cycle; it never exceeds LATENCIA+1.
REQ-027 EN falling mid-operation: no new grants; all tags already issued still complete and strobe.

Reset
REQ-028 With RSTa=0 at a clock edge: all tags cleared, round-robin pointer set to favour requester 0, div_start=0, div_num/div_den=0, all resN_* outputs 0, OCUPADO=0.
REQ-029 Reset mid-operation discards all in-flight results; no result strobe occurs for operations issued before reset.
REQ-030 reqN_ready SHALL be 0 while RSTa=0.

Structure
REQ-031 Shared package div_pkg holds TAMANYO and LATENCIA defaults and the tag struct typedef {valid, id, err}.
REQ-032 Sub-module tag_pipe implements the LATENCIA-deep tag shift register with synchronous active-low clear.
REQ-033 div_arbiter instantiates tag_pipe and contains the arbiter, issue registers, result capture and OCUPADO counter.

Verification
REQ-034 Only requester 0 sends 13/4 at cycle 0 -> div_start at cycle 1; res0_valid at cycle 18 with coc=3, res=1, err=0; res1_valid never asserts.
REQ-035 Both requesters valid for 4 cycles after reset (0: 15/2, 1: 9/3) -> grants alternate 0,1,0,1; results strobe on consecutive cycles 18..21 with 7r1, 3r0, 7r1, 3r0.
REQ-036 Requester 1 sends 5/0 -> res1_valid at +18 cycles with coc=4'hF, res=0, err=1.
REQ-037 17 back-to-back issues -> OCUPADO peaks at 17 with no overflow, then drains to 0 one per cycle.
REQ-038 RSTa=0 for one cycle while 5 operations are in flight -> no resN_valid afterwards, OCUPADO=0, next transfer is granted to requester 0.
REQ-039 EN=0 while both requesters are valid -> both ready outputs stay 0; earlier in-flight results still strobe on schedule.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the two-requester divider arbiter.
// Holds default operand width and divider latency, plus the tag that
// travels alongside each operation while the divider computes it.
package div_pkg;

    localparam int DEF_TAMANYO  = 4;   // operand/result width
    localparam int DEF_LATENCIA = 16;  // divider pipeline depth in cycles

    // One tag per issued operation: occupancy, owner and divide-by-zero flag.
    typedef struct packed {
        logic valid;
        logic id;
        logic err;
    } tag_t;

endpackage

// File: rtl/div_arbiter_if.sv
// Bus bundle between the requesters/divider and div_arbiter.
// slave  : view used by div_arbiter (consumes requests and divider results).
// master : view used by whatever drives the requests and models the divider.
// Signals: EN, reqN_{valid,num,den,ready}, div_{start,num,den,coc,res},
//          resN_{valid,coc,res,err}, OCUPADO.
interface div_arbiter_if #(
    parameter int TAMANYO = 4,
    parameter int OCU_W   = 5
);
    logic               EN;
    logic               req0_valid, req1_valid;
    logic [TAMANYO-1:0] req0_num, req0_den, req1_num, req1_den;
    logic               req0_ready, req1_ready;
    logic               div_start;
    logic [TAMANYO-1:0] div_num, div_den;
    logic [TAMANYO-1:0] div_coc, div_res;
    logic               res0_valid, res1_valid;
    logic [TAMANYO-1:0] res0_coc, res0_res, res1_coc, res1_res;
    logic               res0_err, res1_err;
    logic [OCU_W-1:0]   OCUPADO;

    modport slave (
        input  EN, req0_valid, req1_valid, req0_num, req0_den, req1_num, req1_den,
        input  div_coc, div_res,
        output req0_ready, req1_ready, div_start, div_num, div_den,
        output res0_valid, res1_valid, res0_coc, res0_res, res1_coc, res1_res,
        output res0_err, res1_err, OCUPADO
    );

    modport master (
        output EN, req0_valid, req1_valid, req0_num, req0_den, req1_num, req1_den,
        output div_coc, div_res,
        input  req0_ready, req1_ready, div_start, div_num, div_den,
        input  res0_valid, res1_valid, res0_coc, res0_res, res1_coc, res1_res,
        input  res0_err, res1_err, OCUPADO
    );
endinterface

// File: rtl/div_arbiter_tag_pipe.sv
// Fixed-depth tag shift register that shadows the divider pipeline.
// Advances every cycle and never stalls, so the tag leaving the last stage
// lines up with the divider result of the same operation.
// Ports: clk_i, clr_n_i (synchronous active-low clear), tag_i, tag_o.
module tag_pipe
    import div_pkg::*;
#(
    parameter int DEPTH = DEF_LATENCIA   // must be >= 2
) (
    input  logic clk_i,
    input  logic clr_n_i,
    input  tag_t tag_i,
    output tag_t tag_o
);
    tag_t [DEPTH-1:0] stage_q;

    always_ff @(posedge clk_i) begin
        if (!clr_n_i) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[DEPTH-2:0], tag_i};
        end
    end

    assign tag_o = stage_q[DEPTH-1];
endmodule

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one fixed-latency divider between two requesters.
// Grants one request per cycle, registers the operands towards the divider,
// tracks each operation with a tag and steers the divider output back to the
// owner when the tag emerges. Divide-by-zero is flagged at accept time and the
// result is overridden on the way out.
// Ports: CLK, RSTa (synchronous active-low), bus (div_arbiter_if.slave).
module div_arbiter
    import div_pkg::*;
#(
    parameter int TAMANYO  = DEF_TAMANYO,
    parameter int LATENCIA = DEF_LATENCIA
) (
    input logic          CLK,
    input logic          RSTa,
    div_arbiter_if.slave bus
);
    localparam int OCU_W = $clog2(LATENCIA + 2);

    // ---------------- arbitration ----------------
    logic               prio_q;      // requester favoured when both are valid
    logic               grant0, grant1, xfer, gid;
    logic [TAMANYO-1:0] sel_num, sel_den;

    // Gating with RSTa keeps ready low while reset is held.
    assign grant0  = RSTa & bus.EN & bus.req0_valid & (~bus.req1_valid | ~prio_q);
    assign grant1  = RSTa & bus.EN & bus.req1_valid & (~bus.req0_valid |  prio_q);
    assign xfer    = grant0 | grant1;
    assign gid     = grant1;
    assign sel_num = gid ? bus.req1_num : bus.req0_num;
    assign sel_den = gid ? bus.req1_den : bus.req0_den;

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    // ---------------- issue ----------------
    logic               start_q;
    logic [TAMANYO-1:0] num_q, den_q;
    tag_t               itag_q, otag;

    always_ff @(posedge CLK) begin
        if (!RSTa) begin
            prio_q  <= 1'b0;
            start_q <= 1'b0;
            num_q   <= '0;
            den_q   <= '0;
            itag_q  <= '0;
        end else begin
            start_q <= xfer;
            itag_q  <= '{valid: xfer, id: gid, err: (sel_den == '0)};
            if (xfer) begin
                num_q  <= sel_num;
                den_q  <= sel_den;
                prio_q <= ~gid;
            end
        end
    end

    assign bus.div_start = start_q;
    assign bus.div_num   = num_q;
    assign bus.div_den   = den_q;

    // The tag enters alongside div_start, so after LATENCIA stages it exits
    // in the same cycle the divider presents that operation's result.
    tag_pipe #(.DEPTH(LATENCIA)) u_tag_pipe (
        .clk_i   (CLK),
        .clr_n_i (RSTa),
        .tag_i   (itag_q),
        .tag_o   (otag)
    );

    // ---------------- result capture ----------------
    logic               r0_v_q, r1_v_q, r0_e_q, r1_e_q;
    logic [TAMANYO-1:0] r0_c_q, r0_r_q, r1_c_q, r1_r_q;
    logic [TAMANYO-1:0] cap_coc, cap_res;

    assign cap_coc = otag.err ? '1 : bus.div_coc;
    assign cap_res = otag.err ? '0 : bus.div_res;

    always_ff @(posedge CLK) begin
        if (!RSTa) begin
            r0_v_q <= 1'b0; r0_c_q <= '0; r0_r_q <= '0; r0_e_q <= 1'b0;
            r1_v_q <= 1'b0; r1_c_q <= '0; r1_r_q <= '0; r1_e_q <= 1'b0;
        end else begin
            r0_v_q <= otag.valid & ~otag.id;
            r1_v_q <= otag.valid &  otag.id;
            if (otag.valid && !otag.id) begin
                r0_c_q <= cap_coc; r0_r_q <= cap_res; r0_e_q <= otag.err;
            end
            if (otag.valid && otag.id) begin
                r1_c_q <= cap_coc; r1_r_q <= cap_res; r1_e_q <= otag.err;
            end
        end
    end

    assign bus.res0_valid = r0_v_q;
    assign bus.res0_coc   = r0_c_q;
    assign bus.res0_res   = r0_r_q;
    assign bus.res0_err   = r0_e_q;
    assign bus.res1_valid = r1_v_q;
    assign bus.res1_coc   = r1_c_q;
    assign bus.res1_res   = r1_r_q;
    assign bus.res1_err   = r1_e_q;

    // ---------------- occupancy ----------------
    // Counted from div_start to the result strobe, which bounds it at
    // LATENCIA+1 under back-to-back issue.
    logic [OCU_W-1:0] occ_q, occ_d;
    logic             res_any;

    assign res_any = r0_v_q | r1_v_q;

    always_comb begin
        occ_d = occ_q;
        if (start_q && !res_any)      occ_d = occ_q + 1'b1;
        else if (!start_q && res_any) occ_d = occ_q - 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (!RSTa) occ_q <= '0;
        else       occ_q <= occ_d;
    end

    assign bus.OCUPADO = occ_q;
endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter with a behavioural divider and a
// cycle-indexed reference model of grants, issue, occupancy and results.
module tb_div_arbiter;
    import div_pkg::*;

    localparam int W  = DEF_TAMANYO;
    localparam int L  = DEF_LATENCIA;
    localparam int OW = $clog2(L + 2);

    logic CLK = 1'b0;
    logic RSTa = 1'b0;
    always #5 CLK = ~CLK;

    div_arbiter_if #(.TAMANYO(W), .OCU_W(OW)) bus ();

    div_arbiter #(.TAMANYO(W), .LATENCIA(L)) dut (
        .CLK  (CLK),
        .RSTa (RSTa),
        .bus  (bus)
    );

    // Behavioural divider: L cycles from div_start to quotient/remainder.
    // Divide-by-zero returns junk so the arbiter's override is exercised.
    logic [2*W-1:0] dq [L];
    always @(posedge CLK) begin
        for (int k = L - 1; k > 0; k--) dq[k] <= dq[k-1];
        if (bus.div_den == '0) dq[0] <= {W'(5), W'(2)};
        else                   dq[0] <= {bus.div_num / bus.div_den, bus.div_num % bus.div_den};
    end
    assign bus.div_coc = dq[L-1][2*W-1:W];
    assign bus.div_res = dq[L-1][W-1:0];

    // ---------------- reference model ----------------
    typedef struct {
        int           scyc;
        bit           id;
        logic [W-1:0] coc, res;
        bit           err;
    } exp_t;

    exp_t         exp_q[$];
    int           iss_q[$];
    int           now;
    bit           m_prio;
    bit           pend_ds;
    logic [W-1:0] pend_num, pend_den;

    int           rdy_err, ds_err, occ_err, sb_err, n_strobe, n_xfer, occ_max, rdy_any;
    int           last_scyc;
    bit           last_id;
    logic [W-1:0] last_coc, last_res;
    bit           last_err;
    int           checks, passes;

    task automatic zero_cnt();
        rdy_err = 0; ds_err = 0; occ_err = 0; sb_err = 0;
        n_strobe = 0; n_xfer = 0; occ_max = 0; rdy_any = 0;
        last_scyc = -1;
    endtask

    task automatic drive(input bit v0, input int n0, input int d0,
                         input bit v1, input int n1, input int d1);
        bus.req0_valid = v0; bus.req0_num = W'(n0); bus.req0_den = W'(d0);
        bus.req1_valid = v1; bus.req1_num = W'(n1); bus.req1_den = W'(d1);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    // One clock cycle: sample outputs mid-cycle, update model, advance.
    task automatic cyc();
        bit           e0, e1, ev0, ev1;
        int           eo;
        exp_t         e;
        logic [W-1:0] n, d, c, r;
        #1;
        e0 = RSTa && bus.EN && bus.req0_valid && (!bus.req1_valid || !m_prio);
        e1 = RSTa && bus.EN && bus.req1_valid && (!bus.req0_valid ||  m_prio);
        if (bus.req0_ready !== e0 || bus.req1_ready !== e1) rdy_err++;
        if (bus.req0_ready === 1'b1 || bus.req1_ready === 1'b1) rdy_any++;
        if (bus.div_start !== pend_ds ||
            (pend_ds && (bus.div_num !== pend_num || bus.div_den !== pend_den))) ds_err++;

        while (iss_q.size() > 0 && iss_q[0] + L + 2 < now) void'(iss_q.pop_front());
        eo = 0;
        foreach (iss_q[i]) if (iss_q[i] + 2 <= now) eo++;
        if (bus.OCUPADO !== OW'(eo)) occ_err++;
        if (!$isunknown(bus.OCUPADO) && int'(bus.OCUPADO) > occ_max) occ_max = int'(bus.OCUPADO);

        ev0 = 0; ev1 = 0;
        if (exp_q.size() > 0 && exp_q[0].scyc == now) begin
            e = exp_q.pop_front();
            ev0 = !e.id; ev1 = e.id;
        end
        if (bus.res0_valid !== ev0 || bus.res1_valid !== ev1) sb_err++;
        else if (ev0 && {bus.res0_coc, bus.res0_res, bus.res0_err} !== {e.coc, e.res, e.err}) sb_err++;
        else if (ev1 && {bus.res1_coc, bus.res1_res, bus.res1_err} !== {e.coc, e.res, e.err}) sb_err++;
        if (bus.res0_valid === 1'b1) begin
            n_strobe++; last_scyc = now; last_id = 0;
            last_coc = bus.res0_coc; last_res = bus.res0_res; last_err = bus.res0_err;
        end
        if (bus.res1_valid === 1'b1) begin
            n_strobe++; last_scyc = now; last_id = 1;
            last_coc = bus.res1_coc; last_res = bus.res1_res; last_err = bus.res1_err;
        end

        pend_ds = e0 | e1;
        if (e0 | e1) begin
            n = e1 ? bus.req1_num : bus.req0_num;
            d = e1 ? bus.req1_den : bus.req0_den;
            pend_num = n; pend_den = d;
            c = (d == 0) ? {W{1'b1}} : n / d;
            r = (d == 0) ? '0 : n % d;
            exp_q.push_back('{now + L + 2, e1, c, r, d == 0});
            iss_q.push_back(now);
            m_prio = !e1;
            n_xfer++;
        end
        if (!RSTa) begin
            exp_q.delete(); iss_q.delete();
            m_prio = 0; pend_ds = 0;
        end
        @(posedge CLK);
        @(negedge CLK);
        now++;
    endtask

    task automatic pulse_reset();
        idle(); RSTa = 0; cyc(); RSTa = 1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RSTa = 0; bus.EN = 1;
        drive(1, 3, 1, 1, 4, 2);
        repeat (3) cyc();
        zero_cnt();
        repeat (2) cyc();
        #1;
        checks++;
        if ({bus.req0_ready, bus.req1_ready, bus.div_start, bus.res0_valid, bus.res1_valid} !== 5'b0)
            $display("FAIL reset_ctrl: got %b want 00000",
                     {bus.req0_ready, bus.req1_ready, bus.div_start, bus.res0_valid, bus.res1_valid});
        else passes++;
        checks++;
        if ({bus.div_num, bus.div_den} !== '0)
            $display("FAIL reset_div_ops: got %h want 0", {bus.div_num, bus.div_den});
        else passes++;
        checks++;
        if ({bus.res0_coc, bus.res0_res, bus.res0_err, bus.res1_coc, bus.res1_res, bus.res1_err} !== '0)
            $display("FAIL reset_results: got %h want 0",
                     {bus.res0_coc, bus.res0_res, bus.res0_err, bus.res1_coc, bus.res1_res, bus.res1_err});
        else passes++;
        checks++;
        if (bus.OCUPADO !== '0) $display("FAIL reset_ocupado: got %0d want 0", bus.OCUPADO);
        else passes++;
        checks++;
        if (rdy_any !== 0) $display("FAIL reset_ready: ready seen %0d cycles want 0", rdy_any);
        else passes++;
        idle(); RSTa = 1;
        cyc();
    endtask

    task automatic test_single();
        int t0;
        zero_cnt(); t0 = now;
        drive(1, 13, 4, 0, 0, 0); cyc();
        idle(); repeat (L + 4) cyc();
        checks++;
        if (n_strobe !== 1) $display("FAIL single_count: got %0d want 1", n_strobe); else passes++;
        checks++;
        if (last_scyc !== t0 + 18) $display("FAIL single_time: got %0d want %0d", last_scyc, t0 + 18); else passes++;
        checks++;
        if ({last_id, last_coc, last_res, last_err} !== {1'b0, 4'd3, 4'd1, 1'b0})
            $display("FAIL single_value: got id%0d %0d r%0d e%0d want id0 3 r1 e0", last_id, last_coc, last_res, last_err);
        else passes++;
        checks++;
        if (sb_err + ds_err + rdy_err + occ_err !== 0)
            $display("FAIL single_model: sb %0d ds %0d rdy %0d occ %0d want 0", sb_err, ds_err, rdy_err, occ_err);
        else passes++;
    endtask

    task automatic test_alternate();
        int t0;
        logic [1:0] g [4];
        pulse_reset();
        zero_cnt(); t0 = now;
        drive(1, 15, 2, 1, 9, 3);
        for (int i = 0; i < 4; i++) begin
            #1; g[i] = {bus.req1_ready, bus.req0_ready};
            cyc();
        end
        idle(); repeat (L + 4) cyc();
        checks++;
        if ({g[0], g[1], g[2], g[3]} !== 8'b01_10_01_10)
            $display("FAIL alt_grants: got %b want 01100110", {g[0], g[1], g[2], g[3]});
        else passes++;
        checks++;
        if (n_strobe !== 4 || last_scyc !== t0 + 21)
            $display("FAIL alt_strobes: got %0d last %0d want 4 last %0d", n_strobe, last_scyc, t0 + 21);
        else passes++;
        checks++;
        if ({last_id, last_coc, last_res} !== {1'b1, 4'd3, 4'd0})
            $display("FAIL alt_last: got id%0d %0d r%0d want id1 3 r0", last_id, last_coc, last_res);
        else passes++;
        checks++;
        if (sb_err + ds_err + rdy_err + occ_err !== 0)
            $display("FAIL alt_model: sb %0d ds %0d rdy %0d occ %0d want 0", sb_err, ds_err, rdy_err, occ_err);
        else passes++;
    endtask

    task automatic test_div0();
        int t0;
        zero_cnt(); t0 = now;
        drive(0, 0, 0, 1, 5, 0); cyc();
        idle(); repeat (L + 4) cyc();
        checks++;
        if (n_strobe !== 1 || last_scyc !== t0 + 18)
            $display("FAIL div0_time: got %0d at %0d want 1 at %0d", n_strobe, last_scyc, t0 + 18);
        else passes++;
        checks++;
        if ({last_id, last_coc, last_res, last_err} !== {1'b1, 4'hF, 4'h0, 1'b1})
            $display("FAIL div0_value: got id%0d %h r%h e%0d want id1 f r0 e1", last_id, last_coc, last_res, last_err);
        else passes++;
        checks++;
        if (sb_err !== 0) $display("FAIL div0_model: sb %0d want 0", sb_err); else passes++;
    endtask

    task automatic test_back_to_back();
        bit v0;
        zero_cnt();
        repeat (17) begin
            v0 = 1'($urandom);
            drive(v0, $urandom_range(0, 15), $urandom_range(0, 15),
                  v0 ? 1'($urandom) : 1'b1, $urandom_range(0, 15), $urandom_range(0, 15));
            cyc();
        end
        idle(); repeat (L + 4) cyc();
        checks++;
        if (occ_max !== 17) $display("FAIL b2b_peak: got %0d want 17", occ_max); else passes++;
        checks++;
        if (bus.OCUPADO !== '0 || occ_err !== 0)
            $display("FAIL b2b_drain: got %0d errs %0d want 0 errs 0", bus.OCUPADO, occ_err);
        else passes++;
        checks++;
        if (n_strobe !== 17) $display("FAIL b2b_count: got %0d want 17", n_strobe); else passes++;
        checks++;
        if (sb_err + ds_err + rdy_err !== 0)
            $display("FAIL b2b_model: sb %0d ds %0d rdy %0d want 0", sb_err, ds_err, rdy_err);
        else passes++;
    endtask

    task automatic test_reset_mid();
        logic [1:0] g;
        zero_cnt();
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 0) drive(1, $urandom_range(0, 15), $urandom_range(1, 15), 0, 0, 0);
            else            drive(0, 0, 0, 1, $urandom_range(0, 15), $urandom_range(1, 15));
            cyc();
        end
        idle(); repeat (2) cyc();
        pulse_reset();
        repeat (L + 4) cyc();
        checks++;
        if (n_strobe !== 0) $display("FAIL rstmid_strobes: got %0d want 0", n_strobe); else passes++;
        checks++;
        if (bus.OCUPADO !== '0 || occ_err !== 0)
            $display("FAIL rstmid_ocupado: got %0d errs %0d want 0 errs 0", bus.OCUPADO, occ_err);
        else passes++;
        drive(1, 7, 7, 1, 8, 2);
        #1; g = {bus.req1_ready, bus.req0_ready};
        cyc();
        checks++;
        if (g !== 2'b01) $display("FAIL rstmid_grant: got %b want 01", g); else passes++;
        idle(); repeat (L + 4) cyc();
    endtask

    task automatic test_enable();
        int t0;
        zero_cnt(); t0 = now;
        drive(1, 11, 3, 0, 0, 0); cyc();
        drive(0, 0, 0, 1, 14, 5); cyc();
        drive(1, 9, 0, 0, 0, 0);  cyc();
        bus.EN = 0; rdy_any = 0;
        drive(1, 6, 2, 1, 12, 4);
        repeat (L + 4) cyc();
        checks++;
        if (rdy_any !== 0) $display("FAIL en_ready: ready seen %0d cycles want 0", rdy_any); else passes++;
        checks++;
        if (n_strobe !== 3 || last_scyc !== t0 + 20)
            $display("FAIL en_drain: got %0d last %0d want 3 last %0d", n_strobe, last_scyc, t0 + 20);
        else passes++;
        checks++;
        if (sb_err + rdy_err !== 0) $display("FAIL en_model: sb %0d rdy %0d want 0", sb_err, rdy_err); else passes++;
        bus.EN = 1; idle(); cyc();
    endtask

    task automatic test_random();
        zero_cnt();
        repeat (300) begin
            bus.EN = ($urandom_range(0, 9) != 0);
            drive(1'($urandom), $urandom_range(0, 15), $urandom_range(0, 15),
                  1'($urandom), $urandom_range(0, 15), $urandom_range(0, 15));
            cyc();
        end
        bus.EN = 1; idle(); repeat (L + 4) cyc();
        checks++;
        if (n_strobe !== n_xfer) $display("FAIL rand_count: got %0d want %0d", n_strobe, n_xfer); else passes++;
        checks++;
        if (sb_err !== 0) $display("FAIL rand_results: errs %0d want 0", sb_err); else passes++;
        checks++;
        if (rdy_err + ds_err !== 0) $display("FAIL rand_issue: rdy %0d ds %0d want 0", rdy_err, ds_err); else passes++;
        checks++;
        if (occ_err !== 0) $display("FAIL rand_ocupado: errs %0d want 0", occ_err); else passes++;
    endtask

    initial begin
        checks = 0; passes = 0; now = 0;
        m_prio = 0; pend_ds = 0; pend_num = '0; pend_den = '0;
        bus.EN = 1; idle();
        zero_cnt();
        test_reset();
        test_single();
        test_alternate();
        test_div0();
        test_back_to_back();
        test_reset_mid();
        test_enable();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
